// File: rtl/ram_port_arbiter_pkg.sv
// Shared defaults and helpers for the RAM port arbiter.
// Exports default geometry and a round-robin index helper.
package ram_port_arbiter_pkg;

    localparam int N_CORES_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 12;
    localparam int DEPTH_DEF      = 256;

    function automatic int rr_index(
        input int base,
        input int off,
        input int n
    );
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: req in, one-hot grant out.
// Ports: clock, reset (async high), req[N], grant[N].
module rr_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
)(
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // ptr holds the search start, i.e. last_grant + 1.
    // Reset value 0 gives core 0 highest priority.
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] j;
    logic          any;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        any      = 1'b0;
        j        = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'(rr_index(int'(ptr), i, N));
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                ptr_next = IW'(rr_index(int'(j), 1, N));
            end
        end
        if (reset) begin
            grant = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Multiplexes N cores onto one single-port sync RAM, round-robin.
// Ports: clock, reset, req/we/addr/wdata (per core), ack, rvalid,
// rdata, ram_address/ram_dataIn/ram_WriteEn (to RAM), ram_dataOut.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int N_CORES    = N_CORES_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_CORES-1:0]            req,
    input  logic [N_CORES-1:0]            we,
    input  logic [N_CORES*ADDR_WIDTH-1:0] addr,
    input  logic [N_CORES*DATA_WIDTH-1:0] wdata,
    output logic [N_CORES-1:0]            ack,
    output logic [N_CORES-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         ram_address,
    output logic [DATA_WIDTH-1:0]         ram_dataIn,
    output logic                          ram_WriteEn,
    input  logic [DATA_WIDTH-1:0]         ram_dataOut
);

    logic [N_CORES-1:0] rd_pend;

    rr_arbiter #(.N(N_CORES)) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .grant (ack)
    );

    // ack is one-hot, so at most one core drives the bus.
    always_comb begin
        ram_address = '0;
        ram_dataIn  = '0;
        ram_WriteEn = 1'b0;
        for (int k = 0; k < N_CORES; k++) begin
            if (ack[k]) begin
                ram_address = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                ram_dataIn  = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                ram_WriteEn = we[k];
            end
        end
    end

    // Tag follows the RAM's one-cycle read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend <= '0;
        end else begin
            rd_pend <= ack & ~we;
        end
    end

    assign rvalid = rd_pend;
    assign rdata  = ram_dataOut;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized + directed bench for ram_port_arbiter with a RAM model.
// Scoreboard queue of expected read returns, checked by a monitor.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int AW = 8;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   ram_address;
    logic [DW-1:0]   ram_dataIn;
    logic            ram_WriteEn;
    logic [DW-1:0]   ram_dataOut;

    ram_port_arbiter #(
        .N_CORES(N), .DATA_WIDTH(DW), .DEPTH(256), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .ack(ack), .rvalid(rvalid),
        .rdata(rdata), .ram_address(ram_address),
        .ram_dataIn(ram_dataIn), .ram_WriteEn(ram_WriteEn),
        .ram_dataOut(ram_dataOut)
    );

    // Single-port synchronous RAM, registered read.
    logic [DW-1:0] mem [256];
    always @(posedge clock) begin
        if (ram_WriteEn) mem[ram_address] <= ram_dataIn;
        ram_dataOut <= mem[ram_address];
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // Reference model: arbitration rule, memory contents, expected returns.
    typedef struct {
        int            due;
        int            core;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] mem_m [256];
    int            next_start = 0;
    logic [N-1:0]  acked_q = '0;

    always @(negedge clock) begin
        int            g;
        logic [N-1:0]  ea;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        if (reset) begin
            next_start = 0;
            sb.delete();
            acked_q = '0;
            chk(ack == '0 && ram_WriteEn == 1'b0 && rvalid == '0,
                "reset_outputs", {ack, rvalid, 3'b0, ram_WriteEn}, 0);
        end else begin
            g = -1;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (next_start + i) % N;
                if (g < 0 && req[c]) g = c;
            end
            ea = '0;
            a  = '0;
            d  = '0;
            w  = 1'b0;
            if (g >= 0) begin
                ea[g] = 1'b1;
                a = addr[g*AW +: AW];
                d = wdata[g*DW +: DW];
                w = we[g];
            end
            chk(ack == ea, "ack", 32'(ack), 32'(ea));
            chk(ram_address == a && ram_dataIn == d && ram_WriteEn == w,
                "ram_bus", {11'b0, ram_WriteEn, ram_dataIn, ram_address},
                {11'b0, w, d, a});
            acked_q = ea;
            if (g >= 0) begin
                next_start = (g + 1) % N;
                if (w) mem_m[a] = d;
                else sb.push_back('{due: cyc + 1, core: g, data: mem_m[a]});
            end
        end
    end

    // Monitor: pops expected read returns when the DUT presents rvalid.
    always @(negedge clock) begin
        exp_t e;
        logic [N-1:0] ev;
        if (!reset) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk(1'b0, "rvalid_missing_late", 0, 32'(e.core));
            end
            if (rvalid != '0) begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e  = sb.pop_front();
                    ev = '0;
                    ev[e.core] = 1'b1;
                    chk(rvalid == ev && rdata == e.data, "read_return",
                        {rvalid, 16'b0, rdata}, {ev, 16'b0, e.data});
                end else begin
                    chk(1'b0, "rvalid_unexpected", 32'(rvalid), 0);
                end
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk(1'b0, "rvalid_missing", 0, 32'(e.core));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_core(input int k, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[k] = r;
        we[k]  = w;
        addr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = '0;
            mem_m[i] = '0;
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset asserted mid-cycle with a write pending.
        step();
        set_core(0, 1'b1, 1'b1, 8'h05, 12'h055);
        set_core(2, 1'b1, 1'b0, 8'h06, 12'h000);
        #1 reset = 1'b1;
        #1;
        chk(ack == '0, "async_reset_ack", 32'(ack), 0);
        chk(ram_WriteEn == 1'b0, "async_reset_we", 32'(ram_WriteEn), 0);
        chk(rvalid == '0, "async_reset_rvalid", 32'(rvalid), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        set_core(0, 1'b0, 1'b0, 8'h00, 12'h000);
        #1;
        chk(ack == 4'b0100, "first_grant_core2", 32'(ack), 32'h4);
        step();
        req = '0;
        step();

        // Write then read back from core 1.
        set_core(1, 1'b1, 1'b1, 8'h10, 12'hABC);
        step();
        set_core(1, 1'b1, 1'b0, 8'h10, 12'h000);
        step();
        req = '0;
        @(negedge clock);
        chk(rvalid == 4'b0010 && rdata == 12'hABC, "write_read",
            {rvalid, 16'b0, rdata}, {4'b0010, 16'b0, 12'hABC});
        step();

        // Continuous round-robin from reset.
        do_reset();
        for (int k = 0; k < N; k++)
            set_core(k, 1'b1, 1'b0, AW'(8'h20 + k), 12'h000);
        for (int i = 0; i < 8; i++) begin
            logic [N-1:0] ea;
            logic [N-1:0] ev;
            @(negedge clock);
            ea = '0;
            ea[i % N] = 1'b1;
            ev = '0;
            if (i > 0) ev[(i - 1) % N] = 1'b1;
            chk(ack == ea, "rr_ack", 32'(ack), 32'(ea));
            chk(rvalid == ev, "rr_rvalid", 32'(rvalid), 32'(ev));
        end
        step();
        req = '0;
        step();

        // Pipelined read / write / read on one address.
        set_core(0, 1'b1, 1'b1, 8'h01, 12'h111);
        step();
        set_core(0, 1'b1, 1'b0, 8'h01, 12'h000);
        step();
        set_core(0, 1'b0, 1'b0, 8'h01, 12'h000);
        set_core(3, 1'b1, 1'b1, 8'h01, 12'h777);
        @(negedge clock);
        chk(rvalid == 4'b0001 && rdata == 12'h111, "mixed_old",
            {rvalid, 16'b0, rdata}, {4'b0001, 16'b0, 12'h111});
        step();
        set_core(3, 1'b0, 1'b0, 8'h00, 12'h000);
        set_core(0, 1'b1, 1'b0, 8'h01, 12'h000);
        step();
        req = '0;
        @(negedge clock);
        chk(rvalid == 4'b0001 && rdata == 12'h777, "mixed_new",
            {rvalid, 16'b0, rdata}, {4'b0001, 16'b0, 12'h777});
        step();

        // Reset in the cycle after a read ack.
        set_core(1, 1'b1, 1'b0, 8'h10, 12'h000);
        step();
        req = '0;
        #1 reset = 1'b1;
        @(negedge clock);
        chk(rvalid == '0, "reset_kills_rvalid", 32'(rvalid), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        set_core(1, 1'b1, 1'b0, 8'h02, 12'h000);
        set_core(3, 1'b1, 1'b0, 8'h03, 12'h000);
        #1;
        chk(ack == 4'b0010, "post_reset_grant", 32'(ack), 32'h2);
        step();
        req = '0;
        step();

        // Idle cycles leave the pointer alone.
        set_core(2, 1'b1, 1'b0, 8'h04, 12'h000);
        step();
        req = '0;
        repeat (10) step();
        for (int k = 0; k < N; k++)
            set_core(k, 1'b1, 1'b0, AW'(k), 12'h000);
        #1;
        chk(ack == 4'b1000, "idle_pointer_hold", 32'(ack), 32'h8);
        step();
        req = '0;
        step();

        // Random traffic; requests held until acked.
        repeat (1500) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] || acked_q[k]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_core(k, 1'b1, 1'($urandom_range(0, 1)),
                                 AW'($urandom_range(0, 15)),
                                 DW'($urandom));
                    else
                        req[k] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        repeat (4) step();
        chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
